// File: rtl/jt900h_udma.sv
// Micro-DMA control-register file and four-channel fixed-priority arbiter for the 900H core.
// Registers are read combinationally; grants, requests and end-of-block pulses are registered.
module jt900h_udma #(
    parameter int NCH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [7:0]  cra,
    input  logic [31:0] crin,
    input  logic        crwe,
    input  logic        bs,
    input  logic        ws,
    output logic [31:0] crout,
    input  logic [3:0]  trg,
    input  logic        dma_xfer,
    input  logic        dma_done,
    output logic        dma_req,
    output logic [1:0]  dmach,
    output logic [3:0]  dma_end
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    logic [31:0] dmas_r [0:NCH-1];
    logic [31:0] dmad_r [0:NCH-1];
    logic [15:0] dmac_r [0:NCH-1];
    logic [7:0]  dmam_r [0:NCH-1];

    logic [3:0]  pending_r, pending_nx_s, clr_s, end_nx_s, be_s;
    logic [31:0] rword_s, wdata_s, merged_s;
    logic [1:0]  dmach_nx_s;
    logic        req_nx_s;
    state_t      state_r, state_nx_s;

    // Replace the enabled byte lanes of a word with the new data
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // Lowest set bit wins: channel 0 has highest priority
    function automatic logic [1:0] lowest_ch(input logic [3:0] p);
        logic [1:0] ch;
        ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (p[i]) ch = 2'(i);
        end
        return ch;
    endfunction

    // Addressed 32-bit word, unshifted; DMAM sits above DMAC in the third bank
    always_comb begin
        rword_s = 32'd0;
        case (cra[7:4])
            4'h0:    rword_s = dmas_r[cra[3:2]];
            4'h1:    rword_s = dmad_r[cra[3:2]];
            4'h2:    rword_s = {8'd0, dmam_r[cra[3:2]], dmac_r[cra[3:2]]};
            default: rword_s = 32'd0;
        endcase
        crout = rword_s >> {cra[1:0], 3'b000};
    end

    // Steer right-aligned write data onto the byte lanes selected by size and address
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = crin;
        if (bs) begin
            be_s    = 4'b0001 << cra[1:0];
            wdata_s = {4{crin[7:0]}};
        end else if (ws) begin
            be_s    = cra[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{crin[15:0]}};
        end else begin
            be_s    = 4'b1111;
            wdata_s = crin;
        end
        merged_s = merge_bytes(rword_s, wdata_s, be_s);
    end

    // Register file; lane 3 of the count/mode word has no storage and is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                dmas_r[i] <= 32'd0;
                dmad_r[i] <= 32'd0;
                dmac_r[i] <= 16'd0;
                dmam_r[i] <= 8'd0;
            end
        end else if (cen && crwe) begin
            case (cra[7:4])
                4'h0: dmas_r[cra[3:2]] <= merged_s;
                4'h1: dmad_r[cra[3:2]] <= merged_s;
                4'h2: begin
                    dmac_r[cra[3:2]] <= merged_s[15:0];
                    dmam_r[cra[3:2]] <= merged_s[23:16];
                end
                default: ;
            endcase
        end
    end

    // Arbiter next state; completion inputs only matter while a channel is granted
    always_comb begin
        state_nx_s = state_r;
        dmach_nx_s = dmach;
        req_nx_s   = dma_req;
        end_nx_s   = 4'b0000;
        clr_s      = 4'b0000;
        case (state_r)
            IDLE: begin
                if (pending_r != 4'b0000) begin
                    state_nx_s = BUSY;
                    req_nx_s   = 1'b1;
                    dmach_nx_s = lowest_ch(pending_r);
                end else begin
                    req_nx_s   = 1'b0;
                end
            end
            BUSY: begin
                if (dma_xfer || dma_done) begin
                    state_nx_s = IDLE;
                    req_nx_s   = 1'b0;
                    clr_s      = 4'b0001 << dmach;
                    if (dma_done) end_nx_s = 4'b0001 << dmach;
                    else          end_nx_s = 4'b0000;
                end else begin
                    req_nx_s   = 1'b1;
                end
            end
            default: begin
                state_nx_s = IDLE;
                req_nx_s   = 1'b0;
            end
        endcase
        // a fresh trigger beats a same-cycle clear
        pending_nx_s = (pending_r & ~clr_s) | trg;
    end

    // Arbiter state and registered outputs, frozen while cen is low
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            pending_r <= 4'b0000;
            dma_req   <= 1'b0;
            dmach     <= 2'd0;
            dma_end   <= 4'b0000;
        end else if (cen) begin
            state_r   <= state_nx_s;
            pending_r <= pending_nx_s;
            dma_req   <= req_nx_s;
            dmach     <= dmach_nx_s;
            dma_end   <= end_nx_s;
        end
    end

endmodule

// File: tb/tb_jt900h_udma.sv
// Directed bench for jt900h_udma: register map, lane steering and arbiter sequencing.
module tb_jt900h_udma;

    logic        clk = 1'b0;
    logic        rst, cen, crwe, bs, ws, dma_xfer, dma_done;
    logic [7:0]  cra;
    logic [31:0] crin, crout;
    logic [3:0]  trg, dma_end;
    logic        dma_req;
    logic [1:0]  dmach;

    int n_checks = 0;
    int n_errors = 0;

    jt900h_udma dut (
        .clk(clk), .rst(rst), .cen(cen), .cra(cra), .crin(crin), .crwe(crwe),
        .bs(bs), .ws(ws), .crout(crout), .trg(trg), .dma_xfer(dma_xfer),
        .dma_done(dma_done), .dma_req(dma_req), .dmach(dmach), .dma_end(dma_end)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic b, input logic w);
        cra = a; crin = d; bs = b; ws = w; crwe = 1'b1;
        step();
        crwe = 1'b0; bs = 1'b0; ws = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        cra = a;
        #1;
        chk(tag, crout, exp);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; crwe = 1'b0; bs = 1'b0; ws = 1'b0;
        dma_xfer = 1'b0; dma_done = 1'b0; cra = 8'h00; crin = 32'd0; trg = 4'b0000;
        step(); step();
        rst = 1'b0;
        chk("rst_req", {31'd0, dma_req}, 32'd0);
        chk("rst_ch", {30'd0, dmach}, 32'd0);
        chk("rst_end", {28'd0, dma_end}, 32'd0);

        // register map and lane steering
        wr(8'h04, 32'h0012_3456, 1'b0, 1'b0);
        rdchk("rd04", 8'h04, 32'h0012_3456);
        rdchk("rd05", 8'h05, 32'h0000_1234);
        rdchk("rd07", 8'h07, 32'h0000_0000);
        for (int a = 0; a < 48; a += 4) begin
            if (a != 4) rdchk($sformatf("zero%02h", a), 8'(a), 32'd0);
        end
        wr(8'h22, 32'h0000_00AB, 1'b1, 1'b0);
        wr(8'h20, 32'h0000_0100, 1'b0, 1'b1);
        rdchk("rd20", 8'h20, 32'h00AB_0100);
        rdchk("rd22", 8'h22, 32'h0000_00AB);
        wr(8'h40, 32'hFFFF_FFFF, 1'b0, 1'b0);
        rdchk("rd40", 8'h40, 32'd0);
        rdchk("rd20_keep", 8'h20, 32'h00AB_0100);
        rdchk("rd04_keep", 8'h04, 32'h0012_3456);
        wr(8'h24, 32'hFFEE_DDCC, 1'b0, 1'b0);
        rdchk("rd24_long", 8'h24, 32'h00EE_DDCC);
        wr(8'h16, 32'h0000_BEEF, 1'b0, 1'b1);
        rdchk("rd14_word", 8'h14, 32'hBEEF_0000);
        // read during write shows the old value until the edge
        cra = 8'h24; crin = 32'h0000_1111; ws = 1'b1; crwe = 1'b1;
        #1;
        chk("rdw_old", crout, 32'h00EE_DDCC);
        step();
        crwe = 1'b0; ws = 1'b0;
        rdchk("rdw_new", 8'h24, 32'h00EE_1111);

        // two triggers, priority, spacing, end pulse
        trg = 4'b1010; step(); trg = 4'b0000;
        step();
        chk("g1_req", {31'd0, dma_req}, 32'd1);
        chk("g1_ch", {30'd0, dmach}, 32'd1);
        dma_xfer = 1'b1; step(); dma_xfer = 1'b0;
        chk("x1_req", {31'd0, dma_req}, 32'd0);
        chk("x1_end", {28'd0, dma_end}, 32'd0);
        step();
        chk("g3_req", {31'd0, dma_req}, 32'd1);
        chk("g3_ch", {30'd0, dmach}, 32'd3);
        dma_done = 1'b1; step(); dma_done = 1'b0;
        chk("d3_req", {31'd0, dma_req}, 32'd0);
        chk("d3_end", {28'd0, dma_end}, 32'h8);

        // cen low freezes everything, including the end pulse and triggers
        cen = 1'b0; trg = 4'b0001;
        repeat (3) step();
        chk("frz_end", {28'd0, dma_end}, 32'h8);
        chk("frz_req", {31'd0, dma_req}, 32'd0);
        trg = 4'b0000; cen = 1'b1;
        step();
        chk("end_clr", {28'd0, dma_end}, 32'd0);
        step(); step();
        chk("no_pend", {31'd0, dma_req}, 32'd0);

        // completion while idle is ignored
        dma_done = 1'b1; step(); dma_done = 1'b0;
        chk("idle_done_end", {28'd0, dma_end}, 32'd0);
        step();
        chk("idle_done_end2", {28'd0, dma_end}, 32'd0);
        chk("idle_done_req", {31'd0, dma_req}, 32'd0);

        // retrigger coinciding with xfer keeps the channel pending
        trg = 4'b0100; step(); trg = 4'b0000;
        step();
        chk("g2_req", {31'd0, dma_req}, 32'd1);
        chk("g2_ch", {30'd0, dmach}, 32'd2);
        trg = 4'b0100; dma_xfer = 1'b1; step(); trg = 4'b0000; dma_xfer = 1'b0;
        chk("x2_req", {31'd0, dma_req}, 32'd0);
        step();
        chk("rg2_req", {31'd0, dma_req}, 32'd1);
        chk("rg2_ch", {30'd0, dmach}, 32'd2);
        dma_xfer = 1'b1; dma_done = 1'b1; step(); dma_xfer = 1'b0; dma_done = 1'b0;
        chk("xd2_end", {28'd0, dma_end}, 32'h4);
        step();
        chk("xd2_req", {31'd0, dma_req}, 32'd0);

        // reset while busy on ch0
        wr(8'h00, 32'hDEAD_BEEF, 1'b0, 1'b0);
        trg = 4'b0001; step(); trg = 4'b0000;
        step();
        chk("g0_req", {31'd0, dma_req}, 32'd1);
        wr(8'h04, 32'h0000_0055, 1'b1, 1'b0);
        chk("busy_wr_req", {31'd0, dma_req}, 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst2_req", {31'd0, dma_req}, 32'd0);
        chk("rst2_ch", {30'd0, dmach}, 32'd0);
        chk("rst2_end", {28'd0, dma_end}, 32'd0);
        rdchk("rst2_rd00", 8'h00, 32'd0);
        rdchk("rst2_rd04", 8'h04, 32'd0);
        rdchk("rst2_rd20", 8'h20, 32'd0);
        step();
        chk("rst2_end2", {28'd0, dma_end}, 32'd0);
        chk("rst2_req2", {31'd0, dma_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
